prod_accumulator: RTL and testbench

Downstream consumer of the 4x4 unsigned array multiplier's 8-bit product (Z7..Z0 bundled as prod[7:0]). Accumulates a programmed number of products into a registered sum. Provides valid/ready handshakes on both sides, so the combinational multiplier array becomes a multiply-accumulate datapath. Typical uses are dot products and running sums over 4-bit operand streams.

---
 rtl/prod_acc_pkg.sv | 18 +
 rtl/acc_sat_add.sv | 27 ++
 rtl/prod_accumulator.sv | 78 +++++++
 tb/tb_prod_accumulator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// Shared types and helpers for the product accumulator: FSM state encoding,
// the largest 4x4 product, and the widened add used to detect carry-out.
package prod_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int unsigned PROD_MAX = 225;

  // One extra bit on top of the operands so the carry-out is never lost.
  function automatic logic [32:0] add_carry(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational accumulate step: acc + zero-extended prod with carry-out.
// Build macro SATURATE_EN clamps the sum to all-ones on carry; otherwise it wraps.
module acc_sat_add
  import prod_acc_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int PROD_W = 8
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  next_acc,
  output logic              carry
);

  logic [32:0] sum;

  // Operands are below 2^ACC_W, so any set bit at ACC_W or above is the carry.
  assign sum   = add_carry(32'(acc), 32'(prod));
  assign carry = |sum[32:ACC_W];

`ifdef SATURATE_EN
  assign next_acc = carry ? '1 : sum[ACC_W-1:0];
`else
  assign next_acc = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accumulator.sv
// Multiply-accumulate back end: sums a programmed burst of multiplier products
// with valid/ready on both sides. Build macro SATURATE_EN selects clamping adds.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              ovf
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic [ACC_W-1:0] next_acc;
  logic             carry;

  acc_sat_add #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W)
  ) u_add (
    .acc     (acc),
    .prod    (prod),
    .next_acc(next_acc),
    .carry   (carry)
  );

  // Outputs depend on state and registers only, never directly on inputs.
  assign prod_ready = (state == ACCUM);
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign res        = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= len;
            state     <= (len != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc       <= next_acc;
            remaining <= remaining - CNT_W'(1);
            if (carry) ovf <= 1'b1;
            if (remaining == CNT_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed self-checking bench for prod_accumulator: a 16-bit and a 10-bit
// accumulator share one input stream so wrap/saturate cases come for free.
module tb_prod_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic [7:0]  prod;
  logic        prod_valid;
  logic        res_ready;

  logic        prod_ready16, res_valid16, busy16, ovf16;
  logic [15:0] res16;
  logic        prod_ready10, res_valid10, busy10, ovf10;
  logic [9:0]  res10;

  int checks = 0;
  int errors = 0;
  int handshakes;

  prod_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready16), .res(res16),
    .res_valid(res_valid16), .res_ready(res_ready), .busy(busy16), .ovf(ovf16)
  );

  prod_accumulator #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready10), .res(res10),
    .res_valid(res_valid10), .res_ready(res_ready), .busy(busy10), .ovf(ovf10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] l, input logic v,
                               input logic [7:0] p, input logic rr);
    start      = s;
    len        = l;
    prod_valid = v;
    prod       = p;
    res_ready  = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 4'd0, 0, 8'd0, 0);
    #2;
    checkOutput("rst_res",        res16, 0);
    checkOutput("rst_res_valid",  res_valid16, 0);
    checkOutput("rst_busy",       busy16, 0);
    checkOutput("rst_prod_ready", prod_ready16, 0);
    checkOutput("rst_ovf",        ovf16, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: basic burst 15+225+100 = 340
    $display("[TB] basic burst");
    applyStimulus(1, 4'd3, 0, 8'd0, 1);
    tick();
    checkOutput("t1_ready", prod_ready16, 1);
    applyStimulus(0, 4'd0, 1, 8'd15, 1);
    tick();
    applyStimulus(0, 4'd0, 1, 8'd225, 1);
    tick();
    applyStimulus(0, 4'd0, 1, 8'd100, 1);
    checkOutput("t1_valid_early", res_valid16, 0);
    tick();
    applyStimulus(0, 4'd0, 0, 8'd0, 1);
    checkOutput("t1_valid", res_valid16, 1);
    checkOutput("t1_res", res16, 340);
    checkOutput("t1_res10", res10, 340);
    checkOutput("t1_ovf", ovf16, 0);
    checkOutput("t1_ready_done", prod_ready16, 0);
    tick();
    checkOutput("t1_valid_drop", res_valid16, 0);
    checkOutput("t1_busy_idle", busy16, 0);

    // 2: gaps and back-pressure, 7+9 = 16
    $display("[TB] gaps and back-pressure");
    applyStimulus(1, 4'd2, 0, 8'd0, 0);
    tick();
    applyStimulus(0, 4'd0, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("t2_gap_ready", prod_ready16, 1);
    checkOutput("t2_gap_acc", res16, 0);
    applyStimulus(0, 4'd0, 1, 8'd7, 0);
    tick();
    applyStimulus(0, 4'd0, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("t2_mid_acc", res16, 7);
    checkOutput("t2_mid_busy", busy16, 1);
    applyStimulus(0, 4'd0, 1, 8'd9, 0);
    tick();
    applyStimulus(0, 4'd0, 0, 8'd0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) applyStimulus(1, 4'd5, 0, 8'd0, 0);
      else        applyStimulus(0, 4'd0, 0, 8'd0, 0);
      checkOutput("t2_hold_valid", res_valid16, 1);
      checkOutput("t2_hold_res", res16, 16);
      tick();
    end
    checkOutput("t2_start_ignored_busy", busy16, 1);
    checkOutput("t2_start_ignored_res", res16, 16);
    applyStimulus(1, 4'd2, 0, 8'd0, 1);
    tick();
    checkOutput("t2_idle", busy16, 0);
    applyStimulus(0, 4'd0, 0, 8'd0, 1);
    tick();
    checkOutput("t2_start_at_exit_ignored", busy16, 0);

    // 3: overflow, 5 x 225 = 1125
    $display("[TB] overflow");
    applyStimulus(1, 4'd5, 0, 8'd0, 1);
    tick();
    applyStimulus(0, 4'd0, 1, 8'd225, 1);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(0, 4'd0, 0, 8'd0, 1);
    checkOutput("t3_valid", res_valid10, 1);
    checkOutput("t3_res16", res16, 1125);
    checkOutput("t3_ovf16", ovf16, 0);
`ifdef SATURATE_EN
    checkOutput("t3_res10", res10, 1023);
`else
    checkOutput("t3_res10", res10, 101);
`endif
    checkOutput("t3_ovf10", ovf10, 1);
    tick();
    tick();
    applyStimulus(1, 4'd1, 0, 8'd0, 1);
    tick();
    checkOutput("t3_ovf_cleared", ovf10, 0);
    applyStimulus(0, 4'd0, 1, 8'd4, 1);
    tick();
    applyStimulus(0, 4'd0, 0, 8'd0, 1);
    checkOutput("t3_next_res10", res10, 4);
    checkOutput("t3_next_ovf10", ovf10, 0);
    checkOutput("t3_next_valid", res_valid10, 1);
    tick();
    tick();

    // 4: zero length
    $display("[TB] zero length");
    applyStimulus(1, 4'd0, 0, 8'd0, 0);
    tick();
    applyStimulus(0, 4'd0, 0, 8'd0, 0);
    checkOutput("t4_valid", res_valid16, 1);
    checkOutput("t4_res", res16, 0);
    checkOutput("t4_ready", prod_ready16, 0);
    checkOutput("t4_busy", busy16, 1);
    applyStimulus(0, 4'd0, 0, 8'd0, 1);
    tick();
    checkOutput("t4_idle", busy16, 0);

    // 5: reset mid-burst
    $display("[TB] reset mid-burst");
    applyStimulus(1, 4'd4, 0, 8'd0, 1);
    tick();
    applyStimulus(0, 4'd0, 1, 8'd10, 1);
    tick();
    applyStimulus(0, 4'd0, 1, 8'd20, 1);
    tick();
    applyStimulus(0, 4'd0, 0, 8'd0, 1);
    checkOutput("t5_partial", res16, 30);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_res", res16, 0);
    checkOutput("t5_rst_busy", busy16, 0);
    checkOutput("t5_rst_ready", prod_ready16, 0);
    checkOutput("t5_rst_valid", res_valid16, 0);
    checkOutput("t5_rst_ovf", ovf16, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t5_idle", busy16, 0);
    applyStimulus(1, 4'd1, 0, 8'd0, 1);
    tick();
    applyStimulus(0, 4'd0, 1, 8'd50, 1);
    tick();
    applyStimulus(0, 4'd0, 0, 8'd0, 1);
    checkOutput("t5_res", res16, 50);
    checkOutput("t5_valid", res_valid16, 1);
    tick();
    tick();

    // 6: max length, 15 x 225 = 3375
    $display("[TB] max length");
    applyStimulus(1, 4'd15, 0, 8'd0, 0);
    tick();
    applyStimulus(0, 4'd0, 1, 8'd225, 0);
    handshakes = 0;
    for (int i = 0; i < 15; i++) begin
      if (prod_ready16 && prod_valid) handshakes++;
      tick();
    end
    checkOutput("t6_handshakes", handshakes, 15);
    checkOutput("t6_ready_after", prod_ready16, 0);
    checkOutput("t6_valid", res_valid16, 1);
    checkOutput("t6_res", res16, 3375);
    checkOutput("t6_ovf", ovf16, 0);
    tick();
    checkOutput("t6_no_extra", res16, 3375);
    applyStimulus(0, 4'd0, 0, 8'd0, 1);
    tick();
    checkOutput("t6_idle", busy16, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
